// File: rtl/pack_poly_group_sequencer.sv
// Walks a polynomial in groups of 8 coefficients: fetches each group, hands it to the
// pack-group stage, and writes the 3 packed bytes it returns into ciphertext RAM.
module pack_poly_group_sequencer #(
  parameter int KYBER_N   = 256,
  parameter int COEFF_W   = 12,
  parameter int GRP_OUT_W = 24,
  parameter int CT_ADDR_W = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [CT_ADDR_W-1:0]   ct_base,
  output logic                   busy,
  output logic                   done,
  output logic                   coef_rd_en,
  output logic [7:0]             coef_rd_addr,
  input  logic [COEFF_W-1:0]     coef_rd_data,
  output logic                   grp_enable,
  output logic [8*COEFF_W-1:0]   grp_coeffs,
  input  logic                   grp_done,
  input  logic [GRP_OUT_W-1:0]   grp_data,
  output logic                   ct_we,
  output logic [CT_ADDR_W-1:0]   ct_addr,
  output logic [7:0]             ct_wdata,
  output logic [3:0]             fsmState
);

  localparam int NGRP = KYBER_N / 8;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_WR0, S_WR1, S_WR2, S_NEXT, S_FIN
  } state_t;

  // Handshakes: start is a 1-cycle request honoured only in S_IDLE; grp_enable is a
  // 1-cycle launch; the group result is taken on the rising edge of grp_done only.

  state_t                 state;
  logic [GW-1:0]          grpIdx;
  logic [3:0]             fetchCnt;
  logic [CT_ADDR_W-1:0]   grpAddr;
  logic [GRP_OUT_W-1:0]   holdData;
  logic                   grpDonePrev;
  logic                   grpRise;

  assign fsmState = state;
  assign grpRise  = grp_done & ~grpDonePrev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      grpIdx       <= '0;
      fetchCnt     <= '0;
      grpAddr      <= '0;
      holdData     <= '0;
      grpDonePrev  <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      coef_rd_en   <= 1'b0;
      coef_rd_addr <= '0;
      grp_enable   <= 1'b0;
      grp_coeffs   <= '0;
      ct_we        <= 1'b0;
      ct_addr      <= '0;
      ct_wdata     <= '0;
    end else begin
      grpDonePrev <= grp_done;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            grpIdx       <= '0;
            grpAddr      <= ct_base;
            fetchCnt     <= '0;
            coef_rd_en   <= 1'b1;
            coef_rd_addr <= '0;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data trails the strobe by one cycle, so the shift starts at count 1
          // and coefficient 8g+0 ends up in the top slot.
          fetchCnt <= fetchCnt + 4'd1;
          if (fetchCnt != 4'd0)
            grp_coeffs <= {grp_coeffs[8*COEFF_W-COEFF_W-1:0], coef_rd_data};
          if (fetchCnt < 4'd7)
            coef_rd_addr <= coef_rd_addr + 8'd1;
          if (fetchCnt == 4'd7)
            coef_rd_en <= 1'b0;
          if (fetchCnt == 4'd8) begin
            grp_enable <= 1'b1;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          grp_enable <= 1'b0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          if (grpRise) begin
            holdData <= grp_data;
            ct_we    <= 1'b1;
            ct_addr  <= grpAddr;
            ct_wdata <= grp_data[23:16];
            state    <= S_WR0;
          end
        end
        S_WR0: begin
          ct_addr  <= ct_addr + CT_ADDR_W'(1);
          ct_wdata <= holdData[15:8];
          state    <= S_WR1;
        end
        S_WR1: begin
          ct_addr  <= ct_addr + CT_ADDR_W'(1);
          ct_wdata <= holdData[7:0];
          state    <= S_WR2;
        end
        S_WR2: begin
          ct_we <= 1'b0;
          state <= S_NEXT;
        end
        S_NEXT: begin
          grpIdx  <= grpIdx + GW'(1);
          grpAddr <= grpAddr + CT_ADDR_W'(3);
          if (grpIdx != GW'(NGRP - 1)) begin
            fetchCnt     <= '0;
            coef_rd_en   <= 1'b1;
            coef_rd_addr <= 8'({GW'(grpIdx + GW'(1)), 3'b000});
            state        <= S_FETCH;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pack_poly_group_sequencer.sv
// Directed bench for pack_poly_group_sequencer with a poly RAM stub and a pack-group stub.
module tb_pack_poly_group_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  ct_base = '0;
  logic        busy, done, coef_rd_en, grp_enable, ct_we;
  logic [7:0]  coef_rd_addr, ct_wdata;
  logic [11:0] coef_rd_data;
  logic [95:0] grp_coeffs;
  logic        grp_done;
  logic [23:0] grp_data;
  logic [9:0]  ct_addr;
  logic [3:0]  fsmState;

  pack_poly_group_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .ct_base(ct_base),
    .busy(busy), .done(done), .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr),
    .coef_rd_data(coef_rd_data), .grp_enable(grp_enable), .grp_coeffs(grp_coeffs),
    .grp_done(grp_done), .grp_data(grp_data), .ct_we(ct_we), .ct_addr(ct_addr),
    .ct_wdata(ct_wdata), .fsmState(fsmState)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nMis = 0;

  logic [11:0] polyMem [0:255];
  int stubMode  = 0;
  int stubDelay = 3;
  int stubHold  = 1;

  always @(posedge clk)
    if (coef_rd_en) coef_rd_data <= polyMem[coef_rd_addr];

  // Pack-group stub: raises grp_done stubDelay cycles after a launch, holds it stubHold cycles.
  int         dlyCnt, holdCnt;
  logic       pend;
  logic [4:0] pendG;
  always @(posedge clk) begin
    if (!reset_n) begin
      grp_done <= 1'b0;
      grp_data <= '0;
      pend     <= 1'b0;
      dlyCnt   <= 0;
      holdCnt  <= 0;
      pendG    <= '0;
    end else begin
      if (grp_done) begin
        if (holdCnt <= 1) grp_done <= 1'b0;
        else holdCnt <= holdCnt - 1;
      end
      if (grp_enable) begin
        pend   <= 1'b1;
        dlyCnt <= stubDelay;
        pendG  <= coef_rd_addr[7:3];
      end else if (pend) begin
        if (dlyCnt <= 1) begin
          pend     <= 1'b0;
          grp_done <= 1'b1;
          holdCnt  <= stubHold;
          grp_data <= (stubMode != 0) ? {8'(pendG), 8'(pendG + 1), 8'(pendG + 2)} : 24'h0;
        end else begin
          dlyCnt <= dlyCnt - 1;
        end
      end
    end
  end

  logic [9:0]  wrAddr[$];
  logic [7:0]  wrData[$];
  logic [95:0] coeffLog[$];
  int          doneCnt = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (ct_we) begin
        wrAddr.push_back(ct_addr);
        wrData.push_back(ct_wdata);
      end
      if (done) doneCnt++;
      if (grp_enable) coeffLog.push_back(grp_coeffs);
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Starts one pass and waits (bounded) for done; optionally re-pulses start during a group.
  task automatic run_op(input logic [9:0] base, input int reStartGrp,
                        output bit ok, output bit sawBusy);
    int  d0;
    bit  rep;
    d0      = doneCnt;
    rep     = 1'b0;
    ok      = 1'b0;
    sawBusy = 1'b0;
    ct_base = base;
    pulse_start();
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
      if (doneCnt != d0) begin
        ok = 1'b1;
        break;
      end
      if (reStartGrp >= 0 && !rep && coef_rd_en && coef_rd_addr[7:3] == reStartGrp[4:0]) begin
        rep = 1'b1;
        pulse_start();
      end
    end
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    nCmp++; if ({busy, done, coef_rd_en, grp_enable, ct_we} !== 5'b0) begin nMis++;
      $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, coef_rd_en, grp_enable, ct_we}); end
    nCmp++; if (ct_addr !== 10'd0 || ct_wdata !== 8'd0 || coef_rd_addr !== 8'd0) begin nMis++;
      $display("FAIL reset_addr ct_addr=%0d ct_wdata=%0d rd_addr=%0d exp=0", ct_addr, ct_wdata, coef_rd_addr); end
    nCmp++; if (grp_coeffs !== 96'd0 || fsmState !== 4'd0) begin nMis++;
      $display("FAIL reset_state coeffs=%h state=%0d exp=0", grp_coeffs, fsmState); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    nCmp++; if (busy !== 1'b0 || ct_we !== 1'b0 || coef_rd_en !== 1'b0) begin nMis++;
      $display("FAIL idle_after_reset busy=%b we=%b rd=%b exp=0", busy, ct_we, coef_rd_en); end
  endtask

  task automatic test_zero_poly();
    int w0, d0;
    bit ok, sb;
    for (int i = 0; i < 256; i++) polyMem[i] = 12'd0;
    stubMode = 0; stubDelay = 3; stubHold = 1;
    w0 = wrAddr.size(); d0 = doneCnt;
    run_op(10'd0, -1, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL zero_timeout got=no_done exp=done"); end
    nCmp++; if (!sb) begin nMis++; $display("FAIL zero_busy got=never_high exp=high"); end
    nCmp++; if (doneCnt - d0 !== 1) begin nMis++; $display("FAIL zero_done_count got=%0d exp=1", doneCnt - d0); end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL zero_write_count got=%0d exp=96", wrAddr.size() - w0); end
    for (int i = 0; i < 96 && w0 + i < wrAddr.size(); i++) begin
      nCmp++;
      if (wrAddr[w0+i] !== 10'(i) || wrData[w0+i] !== 8'h00) begin nMis++;
        $display("FAIL zero_write[%0d] got=%0d:%h exp=%0d:00", i, wrAddr[w0+i], wrData[w0+i], i); end
    end
    nCmp++; if (busy !== 1'b0) begin nMis++; $display("FAIL zero_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_byte_order();
    int w0, d0, c0;
    bit ok, sb;
    logic [95:0] expC;
    for (int i = 0; i < 256; i++) polyMem[i] = 12'(i);
    stubMode = 1; stubDelay = 20; stubHold = 1;
    w0 = wrAddr.size(); d0 = doneCnt; c0 = coeffLog.size();
    run_op(10'd0, -1, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL order_timeout got=no_done exp=done"); end
    nCmp++; if (coeffLog.size() - c0 !== 32) begin nMis++; $display("FAIL order_launch_count got=%0d exp=32", coeffLog.size() - c0); end
    for (int g = 0; g < 32 && c0 + g < coeffLog.size(); g++) begin
      for (int k = 0; k < 8; k++) expC[95 - 12*k -: 12] = 12'(8*g + k);
      nCmp++;
      if (coeffLog[c0+g] !== expC) begin nMis++;
        $display("FAIL order_coeffs[g=%0d] got=%h exp=%h", g, coeffLog[c0+g], expC); end
    end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL order_write_count got=%0d exp=96", wrAddr.size() - w0); end
    for (int i = 0; i < 96 && w0 + i < wrAddr.size(); i++) begin
      nCmp++;
      if (wrAddr[w0+i] !== 10'(i) || wrData[w0+i] !== 8'(i/3 + i%3)) begin nMis++;
        $display("FAIL order_write[%0d] got=%0d:%h exp=%0d:%h", i, wrAddr[w0+i], wrData[w0+i], i, 8'(i/3 + i%3)); end
    end
    nCmp++; if (doneCnt - d0 !== 1) begin nMis++; $display("FAIL order_done_count got=%0d exp=1", doneCnt - d0); end
  endtask

  // grp_done is held long enough to still be high when the next group enters WAIT.
  task automatic test_stale_done();
    int w0, d0;
    bit ok, sb;
    stubMode = 1; stubDelay = 10; stubHold = 16;
    w0 = wrAddr.size(); d0 = doneCnt;
    run_op(10'd0, -1, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL stale_timeout got=no_done exp=done"); end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL stale_write_count got=%0d exp=96", wrAddr.size() - w0); end
    for (int i = 0; i < 96 && w0 + i < wrAddr.size(); i++) begin
      nCmp++;
      if (wrAddr[w0+i] !== 10'(i) || wrData[w0+i] !== 8'(i/3 + i%3)) begin nMis++;
        $display("FAIL stale_write[%0d] got=%0d:%h exp=%0d:%h", i, wrAddr[w0+i], wrData[w0+i], i, 8'(i/3 + i%3)); end
    end
    nCmp++; if (doneCnt - d0 !== 1) begin nMis++; $display("FAIL stale_done_count got=%0d exp=1", doneCnt - d0); end
  endtask

  task automatic test_start_while_busy();
    int w0, d0;
    bit ok, sb;
    stubMode = 1; stubDelay = 3; stubHold = 1;
    w0 = wrAddr.size(); d0 = doneCnt;
    run_op(10'd0, 10, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL restart_timeout got=no_done exp=done"); end
    nCmp++; if (doneCnt - d0 !== 1) begin nMis++; $display("FAIL restart_done_count got=%0d exp=1", doneCnt - d0); end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL restart_write_count got=%0d exp=96", wrAddr.size() - w0); end
    nCmp++; if (busy !== 1'b0) begin nMis++; $display("FAIL restart_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int w0, d0;
    bit ok, sb, hit;
    stubMode = 1; stubDelay = 3; stubHold = 1;
    w0 = wrAddr.size();
    ct_base = 10'd0;
    pulse_start();
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      @(negedge clk);
      if (ct_we && ct_addr == 10'd13) hit = 1'b1;
    end
    nCmp++; if (!hit) begin nMis++; $display("FAIL midrst_reach_wr1 got=not_reached exp=reached"); end
    #1 reset_n = 1'b0;
    #1;
    nCmp++; if ({busy, done, coef_rd_en, grp_enable, ct_we} !== 5'b0 || fsmState !== 4'd0) begin nMis++;
      $display("FAIL midrst_outputs got=%b state=%0d exp=00000 state=0", {busy, done, coef_rd_en, grp_enable, ct_we}, fsmState); end
    nCmp++; if (ct_addr !== 10'd0 || ct_wdata !== 8'd0) begin nMis++;
      $display("FAIL midrst_bus got=%0d:%h exp=0:00", ct_addr, ct_wdata); end
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    nCmp++; if (wrAddr.size() - w0 !== 14) begin nMis++; $display("FAIL midrst_write_count got=%0d exp=14", wrAddr.size() - w0); end
    w0 = wrAddr.size(); d0 = doneCnt;
    run_op(10'd0, -1, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL midrst_rerun_timeout got=no_done exp=done"); end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL midrst_rerun_count got=%0d exp=96", wrAddr.size() - w0); end
    for (int i = 0; i < 96 && w0 + i < wrAddr.size(); i++) begin
      nCmp++;
      if (wrAddr[w0+i] !== 10'(i) || wrData[w0+i] !== 8'(i/3 + i%3)) begin nMis++;
        $display("FAIL midrst_write[%0d] got=%0d:%h exp=%0d:%h", i, wrAddr[w0+i], wrData[w0+i], i, 8'(i/3 + i%3)); end
    end
    nCmp++; if (doneCnt - d0 !== 1) begin nMis++; $display("FAIL midrst_done_count got=%0d exp=1", doneCnt - d0); end
  endtask

  task automatic test_addr_wrap();
    int w0;
    bit ok, sb;
    stubMode = 1; stubDelay = 3; stubHold = 1;
    w0 = wrAddr.size();
    run_op(10'd1020, -1, ok, sb);
    nCmp++; if (!ok) begin nMis++; $display("FAIL wrap_timeout got=no_done exp=done"); end
    nCmp++; if (wrAddr.size() - w0 !== 96) begin nMis++; $display("FAIL wrap_write_count got=%0d exp=96", wrAddr.size() - w0); end
    for (int i = 0; i < 96 && w0 + i < wrAddr.size(); i++) begin
      nCmp++;
      if (wrAddr[w0+i] !== 10'(1020 + i) || wrData[w0+i] !== 8'(i/3 + i%3)) begin nMis++;
        $display("FAIL wrap_write[%0d] got=%0d:%h exp=%0d:%h", i, wrAddr[w0+i], wrData[w0+i], 10'(1020 + i), 8'(i/3 + i%3)); end
    end
  endtask

  initial begin
    test_reset();
    test_zero_poly();
    test_byte_order();
    test_stale_done();
    test_start_while_busy();
    test_reset_mid();
    test_addr_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nMis);
    $finish;
  end

endmodule
